// File: rtl/pipeline_elastic.sv
// Elastic p_stages-deep valid/ready pipeline with bubble collapse, flush and occupancy count.
// Latency p_stages cycles when unstalled; backpressure via combinational ready chain, no skid buffer.
module pipeline_elastic #(
    parameter int p_width = 32,
    parameter int p_stages = 8,
    localparam int p_count_w = $clog2(p_stages + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [p_width-1:0]   i_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [p_width-1:0]   o_data,
    input  logic                 i_flush,
    output logic [p_count_w-1:0] o_count
);

    logic [p_stages-1:0]              valid_q, valid_d;
    logic [p_stages-1:0][p_width-1:0] data_q, data_d;
    logic [p_count_w-1:0]             count_q, count_d;
    logic [p_stages-1:0]              mv;
    logic                             in_xfer, out_xfer;

    // A stage may move if it is empty or everything ahead of it can move.
    always_comb begin : move_chain
        logic m;
        mv = '0;
        m  = !valid_q[p_stages-1] || i_ready;
        mv[p_stages-1] = m;
        for (int k = p_stages - 2; k >= 0; k--) begin
            m     = !valid_q[k] || m;
            mv[k] = m;
        end
    end

    assign o_ready  = mv[0] && !i_flush;
    assign o_valid  = valid_q[p_stages-1];
    assign o_data   = data_q[p_stages-1];
    assign o_count  = count_q;
    assign in_xfer  = i_valid && o_ready;
    assign out_xfer = o_valid && i_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        count_d = count_q;
        if (i_flush) begin
            valid_d = '0;
            count_d = '0;
        end else begin
            if (mv[0]) begin
                valid_d[0] = i_valid;
                if (i_valid) begin
                    data_d[0] = i_data;
                end
            end
            // Data only follows a valid word; bubbles leave stale data behind.
            for (int k = 1; k < p_stages; k++) begin
                if (mv[k]) begin
                    valid_d[k] = valid_q[k-1];
                    if (valid_q[k-1]) begin
                        data_d[k] = data_q[k-1];
                    end
                end
            end
            count_d = count_q + p_count_w'(in_xfer) - p_count_w'(out_xfer);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

endmodule

// File: doc/pipeline_elastic.md
Name: pipeline_elastic

Overview:
Parametrised successor to the fixed shift pipeline. It carries a data word through p_stages register stages, with a valid/ready handshake on both ends. Downstream backpressure stalls the pipe. Bubbles collapse, so upstream data fills empty stages during a stall. A synchronous flush discards all in-flight data. It sits between producer/consumer blocks that need a fixed latency plus flow control.

Parameters:
p_width, 32, data word width in bits (>=1)
p_stages, 8, number of register stages (>=1)
p_count_w, $clog2(p_stages+1), width of occupancy output (derived, not overridden)

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst  input  1  asynchronous active-high reset
i_valid  input  1  upstream word valid
o_ready  output  1  pipeline accepts upstream word this cycle
i_data  input  p_width  upstream word
o_valid  output  1  stage p_stages-1 holds a valid word
i_ready  input  1  downstream accepts the output word this cycle
o_data  output  p_width  word in stage p_stages-1
i_flush  input  1  synchronous flush of all stages
o_count  output  p_count_w  number of valid stages (0..p_stages)

Behaviour:
- State: per stage k (0..p_stages-1), a valid bit v[k] and a data register d[k]. Stage 0 is the input stage; stage p_stages-1 is the output stage.
- Reset (i_rst high, asynchronous): all v[k]=0 and all d[k]=0. Outputs: o_valid=0, o_data=0, o_count=0, o_ready=1 (if i_flush=0).
- Move condition, combinational from output back to input:
  - mv[p_stages-1] = !v[p_stages-1] || i_ready
  - mv[k] = !v[k] || mv[k+1]
- Stage k loads when mv[k]=1:
  - k=0: v[0] <= i_valid, d[0] <= i_data
  - k>0: v[k] <= v[k-1], d[k] <= d[k-1]
- Stage k holds v[k] and d[k] when mv[k]=0.
- d[k] loads only when the incoming valid is 1. On a bubble it keeps its old value; only v marks validity.
- o_ready = mv[0] && !i_flush. The ready path is combinational through all stages; there is no skid buffer.
- Transfers:
  - Input transfer: i_valid && o_ready.
  - Output transfer: o_valid && i_ready.
  - o_valid = v[p_stages-1]; o_data = d[p_stages-1].
- Latency: a word accepted at edge N appears at the output (o_valid=1) after edge N+p_stages-1, i.e. p_stages cycles from input presentation to output visibility, when unstalled.
- Throughput: 1 word/cycle when i_ready is held high.
- Stall: with i_ready=0 and v[last]=1, valid words hold in place. Bubbles ahead of the first blocked stage still advance. A full pipe (all v=1) with i_ready=0 gives o_ready=0.
- Full pipe with i_ready=1: o_ready=1, and input and output transfer in the same cycle.
- Flush (i_flush high at a rising edge):
  - All v[k] <= 0; d unchanged.
  - o_ready=0 during the flush cycle, so no input is accepted.
  - Any output transfer shown that cycle (o_valid && i_ready) still counts as delivered. Downstream must accept it; flush only drops in-flight words.
- Flush and reset: reset overrides flush. i_rst asserted mid-stream clears everything immediately, independent of the clock.
- o_count: a registered count of valid stages, updated every edge.
  - Normal edge: +1 on input transfer, -1 on output transfer, unchanged when both or neither occur.
  - Flush edge: 0.
  - Invariant: o_count equals the popcount of v at all times. The count never exceeds p_stages and never underflows.
- p_stages=1: a single register with combinational o_ready = !v[0] || i_ready.

Test Plan:
- p_width=32, p_stages=4. Reset, then i_valid=1 with data 0x1,0x2,... every cycle and i_ready=1 -> o_valid first high 4 cycles after the first input, o_data 0x1,0x2,... on consecutive cycles, o_count steady at 4.
- Fill with 0xA0..0xA3 and i_ready=0 -> o_ready=0 once o_count=4, o_data holds 0xA0. Then raise i_ready for 1 cycle -> 0xA0 is delivered, 0xA4 is accepted the same cycle, o_count stays 4.
- Insert 2 bubbles between 0xB0 and 0xB1, with i_ready=0 after 0xB0 reaches the output -> 0xB1 collapses forward to stage 2, o_count=2, o_ready stays 1.
- Pipe holds 3 words, then i_flush=1 for 1 cycle with i_valid=1 and data 0xC0 -> o_ready=0 that cycle, next cycle o_valid=0 and o_count=0, and 0xC0 never appears at the output.
- Assert i_rst asynchronously mid-stream, between clock edges -> o_valid, o_data and o_count go to 0 immediately. After release, streaming resumes with the 4-cycle latency.
- Random i_valid/i_ready at 50% for 10k cycles against a scoreboard queue -> output is in order with no loss or duplication, and o_count always equals queue depth (<=4).
